// File: rtl/bsg_dff_en.sv
// bsg_dff_en: width_p-bit register that loads data_i on cycles where en_i is high.
module bsg_dff_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);
    always_ff @(posedge clk_i)
        if (en_i) data_o <= data_i;
endmodule

// File: rtl/bsg_fifo_1r1w_bypass_two.sv
// bsg_fifo_1r1w_bypass_two: two-entry valid/ready FIFO that forwards data_i straight
// to data_o when empty, so an accepted word can be consumed with zero latency.
module bsg_fifo_1r1w_bypass_two #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o
);
    localparam int els_lp       = 2;
    localparam int ptr_width_lp = 1;

    logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [1:0]              count_r;
    logic [width_p-1:0]      mem [els_lp];
    logic                    enq, deq, bypass, write, read, empty;

    assign empty   = (count_r == 2'd0);
    assign ready_o = ~reset_i & (count_r != 2'd2);
    assign v_o     = ~reset_i & (~empty | v_i);
    assign data_o  = empty ? data_i : mem[rd_ptr_r];
    assign count_o = count_r;

    assign enq    = v_i & ready_o;
    assign deq    = yumi_i & ~reset_i;
    assign bypass = enq & deq & empty;
    assign write  = enq & ~bypass;
    assign read   = deq & ~empty;

    for (genvar i = 0; i < els_lp; i++) begin : g_mem
        bsg_dff_en #(.width_p(width_p)) u_ent (
            .clk_i  (clk_i),
            .en_i   (write & (wr_ptr_r == ptr_width_lp'(i))),
            .data_i (data_i),
            .data_o (mem[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r  <= 2'd0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            count_r  <= count_r + 2'(write) - 2'(read);
            rd_ptr_r <= rd_ptr_r ^ ptr_width_lp'(read);
            wr_ptr_r <= wr_ptr_r ^ ptr_width_lp'(write);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
            assert (count_r != 2'd3);
        end
    end
endmodule

// File: tb/tb_bsg_fifo_1r1w_bypass_two.sv
// tb_bsg_fifo_1r1w_bypass_two: directed stimulus with a scoreboard queue of expected
// consumed words, checked by an independent monitor process.
module tb_bsg_fifo_1r1w_bypass_two;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        ready_o, v_o, yumi_i = 1'b0;
    logic [15:0] data_o;
    logic [1:0]  count_o;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    bsg_fifo_1r1w_bypass_two #(.width_p(16)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; checks run 2 time units later.
    task automatic step(input logic r, input logic v, input logic [15:0] d, input logic y);
        @(negedge clk_i);
        reset_i = r;
        v_i     = v;
        data_i  = d;
        yumi_i  = y;
        #2;
    endtask

    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk_i);
            #2;
            if (!reset_i && v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("consumed_word", 32'(data_o), 32'(e));
                end
            end
        end
    end

    initial begin
        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        chk("reset_ready", 32'(ready_o), 0);
        chk("reset_v", 32'(v_o), 0);
        step(0, 0, 16'h0, 0);
        chk("post_reset_count", 32'(count_o), 0);
        chk("post_reset_ready", 32'(ready_o), 1);

        exp_q.push_back(16'hA5A5);
        step(0, 1, 16'hA5A5, 1);
        chk("bypass_v", 32'(v_o), 1);
        chk("bypass_data", 32'(data_o), 32'h0000A5A5);
        step(0, 0, 16'h0, 0);
        chk("bypass_count", 32'(count_o), 0);
        chk("bypass_ready", 32'(ready_o), 1);
        chk("bypass_idle_v", 32'(v_o), 0);

        exp_q.push_back(16'h0001);
        step(0, 1, 16'h0001, 0);
        exp_q.push_back(16'h0002);
        step(0, 1, 16'h0002, 0);
        chk("fill_count1", 32'(count_o), 1);
        chk("fill_head1", 32'(data_o), 32'h1);
        step(0, 1, 16'h0003, 0);
        chk("fill_count2", 32'(count_o), 2);
        chk("full_ready", 32'(ready_o), 0);
        chk("full_head", 32'(data_o), 32'h1);
        step(0, 0, 16'h0, 0);
        chk("full_no_third", 32'(count_o), 2);

        step(0, 0, 16'h0, 1);
        chk("drain_data1", 32'(data_o), 32'h1);
        step(0, 0, 16'h0, 1);
        chk("drain_data2", 32'(data_o), 32'h2);
        chk("drain_count1", 32'(count_o), 1);
        step(0, 0, 16'h0, 0);
        chk("drain_v", 32'(v_o), 0);
        chk("drain_count0", 32'(count_o), 0);

        exp_q.push_back(16'h00AA);
        step(0, 1, 16'h00AA, 0);
        exp_q.push_back(16'h00BB);
        step(0, 1, 16'h00BB, 1);
        chk("simul_head", 32'(data_o), 32'hAA);
        chk("simul_count_before", 32'(count_o), 1);
        step(0, 0, 16'h0, 0);
        chk("simul_count_after", 32'(count_o), 1);
        chk("simul_next", 32'(data_o), 32'hBB);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 0);
        chk("simul_empty", 32'(count_o), 0);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0010 + 16'(i));
            step(0, 1, 16'h0010 + 16'(i), 1);
            chk("stream_v", 32'(v_o), 1);
            chk("stream_count", 32'(count_o), 0);
            chk("stream_data", 32'(data_o), 32'h10 + 32'(i));
        end
        step(0, 0, 16'h0, 0);
        chk("stream_end_count", 32'(count_o), 0);

        step(0, 1, 16'h1111, 0);
        step(0, 1, 16'h2222, 0);
        step(1, 0, 16'h0, 0);
        chk("midreset_v", 32'(v_o), 0);
        chk("midreset_ready", 32'(ready_o), 0);
        step(0, 0, 16'h0, 0);
        chk("after_reset_count", 32'(count_o), 0);
        chk("after_reset_v", 32'(v_o), 0);
        chk("after_reset_ready", 32'(ready_o), 1);
        exp_q.push_back(16'h3333);
        step(0, 1, 16'h3333, 1);
        chk("after_reset_bypass", 32'(data_o), 32'h3333);
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
